// File: rtl/hydra_egress_scheduler.sv
// hydra_egress_scheduler
//
// Per-output-port packet scheduler for the hydra 16-port shared-buffer switch.
// Every downstream ready pulse entitles the port to one packet. The block picks
// which priority queue the read engine drains next, using either strict
// priority (highest index wins) or weighted round robin. Queue p has weight p+1.
// Once a packet is granted, no further grant is issued until the read engine
// reports that packet's end (xfer_done).
//
// Ports
//   clk         single clock
//   rst         asynchronous reset, active-high
//   wrr_enable  1 = weighted round robin, 0 = strict priority
//   queue_vld   bit p set when queue p holds at least one complete packet
//   ready       one-cycle pulse from downstream, one packet per pulse
//   xfer_done   one-cycle pulse from the read engine at the packet's rd_eop
//   grant_vld   one-cycle pulse: start the packet in queue grant_prio
//   grant_prio  selected queue; holds its last value outside grant_vld
//   busy        high whenever a grant is being arbitrated or a packet is in flight
module hydra_egress_scheduler #(
  parameter int NUM_PRIO = 8,
  parameter int PRIO_W   = 3,
  parameter int RDY_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrr_enable,
  input  logic [NUM_PRIO-1:0] queue_vld,
  input  logic                ready,
  input  logic                xfer_done,
  output logic                grant_vld,
  output logic [PRIO_W-1:0]   grant_prio,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    RELOAD = 3'd2,
    GRANT  = 3'd3,
    XFER   = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [RDY_W-1:0]    ready_cnt;
  logic [PRIO_W-1:0]   ptr;
  logic                wrr_q;
  logic [PRIO_W:0]     credit [NUM_PRIO];
  logic                grant_wrr;

  logic [PRIO_W-1:0]   strict_sel;
  logic [PRIO_W-1:0]   wrr_sel;
  logic                wrr_found;
  logic [PRIO_W-1:0]   scan_idx;

  logic                load_sel;
  logic [PRIO_W-1:0]   sel;
  logic                sel_wrr;
  logic [PRIO_W:0]     cred_dec;

  // Pending-ready counter increment that sticks at all-ones.
  function automatic logic [RDY_W-1:0] sat_inc(input logic [RDY_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Initial credit of queue p equals its weight.
  function automatic logic [PRIO_W:0] weight(input int p);
    return (PRIO_W+1)'(p + 1);
  endfunction

  // Highest-index valid queue; also the WRR choice right after a reload,
  // because all credits are then nonzero and the scan starts at the top.
  always_comb begin
    strict_sel = '0;
    for (int p = 0; p < NUM_PRIO; p++) begin
      if (queue_vld[p]) strict_sel = PRIO_W'(p);
    end
  end

  // Downward scan from ptr; the index wraps naturally from 0 to NUM_PRIO-1
  // because NUM_PRIO is a power of two.
  always_comb begin
    wrr_sel   = '0;
    wrr_found = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_PRIO; i++) begin
      scan_idx = ptr - PRIO_W'(i);
      if (!wrr_found && queue_vld[scan_idx] && (credit[scan_idx] != '0)) begin
        wrr_found = 1'b1;
        wrr_sel   = scan_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load_sel  = 1'b0;
    sel       = strict_sel;
    sel_wrr   = 1'b0;
    case (state)
      IDLE: begin
        if ((ready_cnt != '0) && (queue_vld != '0)) state_nxt = ARB;
      end
      ARB: begin
        if (queue_vld == '0) begin
          state_nxt = IDLE;
        end else if (!wrr_enable) begin
          load_sel  = 1'b1;
          sel       = strict_sel;
          state_nxt = GRANT;
        end else if (!wrr_q || !wrr_found) begin
          // WRR just switched on, or every valid queue has spent its credit.
          state_nxt = RELOAD;
        end else begin
          load_sel  = 1'b1;
          sel       = wrr_sel;
          sel_wrr   = 1'b1;
          state_nxt = GRANT;
        end
      end
      RELOAD: begin
        // Arbitration against the freshly reloaded credits happens here, so a
        // reload costs exactly one extra cycle.
        if (queue_vld == '0) begin
          state_nxt = IDLE;
        end else begin
          load_sel  = 1'b1;
          sel       = strict_sel;
          sel_wrr   = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        state_nxt = XFER;
      end
      XFER: begin
        if (xfer_done) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrr_q <= 1'b0;
    end else begin
      wrr_q <= wrr_enable;
    end
  end

  // A ready pulse and a grant in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_cnt <= '0;
    end else begin
      case ({ready, state == GRANT})
        2'b10:   ready_cnt <= sat_inc(ready_cnt);
        2'b01:   ready_cnt <= ready_cnt - 1'b1;
        default: ready_cnt <= ready_cnt;
      endcase
    end
  end

  // The selection is latched on entry to GRANT, so queue_vld changes from
  // then on cannot alter the packet being granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_prio <= '0;
      grant_wrr  <= 1'b0;
    end else if (load_sel) begin
      grant_prio <= sel;
      grant_wrr  <= sel_wrr;
    end
  end

  assign cred_dec = credit[grant_prio] - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PRIO_W'(NUM_PRIO - 1);
      for (int p = 0; p < NUM_PRIO; p++) credit[p] <= weight(p);
    end else if (state == RELOAD) begin
      ptr <= PRIO_W'(NUM_PRIO - 1);
      for (int p = 0; p < NUM_PRIO; p++) credit[p] <= weight(p);
    end else if ((state == GRANT) && grant_wrr) begin
      credit[grant_prio] <= cred_dec;
      // Stay on a queue that still has credit; otherwise move below it.
      ptr <= (cred_dec != '0) ? grant_prio : grant_prio - 1'b1;
    end
  end

  assign grant_vld = (state == GRANT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_hydra_egress_scheduler.sv
// Directed bench for hydra_egress_scheduler: a vector table of single-packet
// transactions (mode, queue_vld, expected queue, expected latency) plus
// hand-written sequences for the multi-cycle corner cases.
module tb_hydra_egress_scheduler;

  logic       clk;
  logic       rst;
  logic       wrr_enable;
  logic [7:0] queue_vld;
  logic       ready;
  logic       xfer_done;
  logic       grant_vld;
  logic [2:0] grant_prio;
  logic       busy;

  int nvec;
  int nerr;

  hydra_egress_scheduler #(
    .NUM_PRIO(8),
    .PRIO_W  (3),
    .RDY_W   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wrr_enable(wrr_enable),
    .queue_vld (queue_vld),
    .ready     (ready),
    .xfer_done (xfer_done),
    .grant_vld (grant_vld),
    .grant_prio(grant_prio),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit       rst_before;
    bit       wrr;
    logic [7:0] qv;
    int       prio;
    int       lat;
  } vec_t;

  vec_t vecs [27];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    ready     = 1'b0;
    xfer_done = 1'b0;
    @(posedge clk); #1;
    check("rst_grant_vld", grant_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_prio", grant_prio, 0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Pulse xfer_done for one cycle; the FSM is expected to be in XFER.
  task automatic finish_xfer();
    xfer_done = 1'b1;
    @(posedge clk); #1;
    xfer_done = 1'b0;
  endtask

  // Wait for grant_vld; lat counts cycles after the ready cycle (cycle 0).
  task automatic wait_grant(input int start, input int limit, output int lat);
    int n;
    n   = start;
    lat = 99;
    while (n <= limit) begin
      if (grant_vld) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    if (v.rst_before) do_reset();
    wrr_enable = v.wrr;
    queue_vld  = v.qv;
    ready      = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    wait_grant(1, 8, lat);
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    if (lat == 99) return;
    check($sformatf("v%0d_prio", idx), grant_prio, v.prio);
    @(posedge clk); #1;
    check($sformatf("v%0d_pulse_width", idx), grant_vld, 0);
    check($sformatf("v%0d_busy_xfer", idx), busy, 1);
    finish_xfer();
    check($sformatf("v%0d_busy_done", idx), busy, 0);
    check($sformatf("v%0d_prio_hold", idx), grant_prio, v.prio);
  endtask

  // Grant and complete packets until none arrives within a window.
  task automatic drain(input int exp_prio, input string nm, output int cnt);
    bit got;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      got = 1'b0;
      for (int w = 0; w < 12 && !got; w++) begin
        @(posedge clk); #1;
        if (grant_vld) got = 1'b1;
      end
      if (!got) break;
      cnt++;
      check({nm, "_prio"}, grant_prio, exp_prio);
      @(posedge clk); #1;
      finish_xfer();
    end
  endtask

  // Count grant_vld cycles over a window.
  task automatic count_grants(input int cycles, output int seen);
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (grant_vld) seen++;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    int seen;

    nvec       = 0;
    nerr       = 0;
    rst        = 1'b1;
    wrr_enable = 1'b0;
    queue_vld  = '0;
    ready      = 1'b0;
    xfer_done  = 1'b0;

    // Strict priority: highest valid index wins, latency 3.
    vecs[0] = '{1'b1, 1'b0, 8'h25, 5, 3};
    vecs[1] = '{1'b0, 1'b0, 8'h25, 5, 3};
    vecs[2] = '{1'b0, 1'b0, 8'h05, 2, 3};
    vecs[3] = '{1'b0, 1'b0, 8'h80, 7, 3};
    vecs[4] = '{1'b0, 1'b0, 8'h01, 0, 3};
    vecs[5] = '{1'b0, 1'b0, 8'hFF, 7, 3};
    vecs[6] = '{1'b0, 1'b0, 8'h7E, 6, 3};
    // WRR with queues 7 and 0: eight grants of 7, one of 0, then a reload
    // that delays the next grant of 7 by one cycle.
    for (int i = 0; i < 20; i++) begin
      vecs[7+i] = '{(i == 0), 1'b1, 8'h81,
                    ((i % 9) == 8) ? 0 : 7,
                    ((i == 9) || (i == 18)) ? 4 : 3};
    end

    for (int i = 0; i < 27; i++) run_vec(vecs[i], i);

    // WRR switched on while in ARB (wrr_q still 0): RELOAD precedes the grant.
    wrr_enable = 1'b0;
    do_reset();
    queue_vld = 8'h81;
    ready     = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    @(posedge clk); #1;
    wrr_enable = 1'b1;
    wait_grant(2, 8, lat);
    check("wrrq_reload_latency", lat, 4);
    check("wrrq_reload_prio", grant_prio, 7);
    @(posedge clk); #1;
    finish_xfer();

    // Ready pulses accumulate while no queue is valid.
    wrr_enable = 1'b0;
    do_reset();
    queue_vld = '0;
    repeat (3) begin
      ready = 1'b1;
      @(posedge clk); #1;
    end
    ready = 1'b0;
    count_grants(5, seen);
    check("accum_no_grant_empty", seen, 0);
    check("accum_idle_busy", busy, 0);
    queue_vld = 8'h02;
    drain(1, "accum", cnt);
    check("accum_grant_count", cnt, 3);

    // Seventeen pulses saturate the counter at fifteen.
    do_reset();
    queue_vld = '0;
    repeat (17) begin
      ready = 1'b1;
      @(posedge clk); #1;
    end
    ready = 1'b0;
    queue_vld = 8'h02;
    drain(1, "sat", cnt);
    check("sat_grant_count", cnt, 15);

    // Queue vanishes while in ARB: back to IDLE, credit for the ready kept.
    do_reset();
    queue_vld = 8'h04;
    ready     = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    @(posedge clk); #1;
    check("vanish_busy_arb", busy, 1);
    queue_vld = '0;
    @(posedge clk); #1;
    check("vanish_grant_vld", grant_vld, 0);
    check("vanish_busy_idle", busy, 0);
    count_grants(6, seen);
    check("vanish_no_grant", seen, 0);
    queue_vld = 8'h04;
    @(posedge clk); #1;
    wait_grant(1, 8, lat);
    check("vanish_regrant_latency", lat, 2);
    check("vanish_regrant_prio", grant_prio, 2);
    @(posedge clk); #1;
    finish_xfer();
    count_grants(8, seen);
    check("vanish_single_grant", seen, 0);

    // Reset during XFER with two ready pulses still pending.
    do_reset();
    queue_vld = 8'h10;
    repeat (3) begin
      ready = 1'b1;
      @(posedge clk); #1;
    end
    ready = 1'b0;
    wait_grant(0, 8, lat);
    check("midrst_first_grant", (lat == 99) ? 0 : 1, 1);
    @(posedge clk); #1;
    check("midrst_busy_xfer", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_grant_vld", grant_vld, 0);
    check("midrst_grant_prio", grant_prio, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_grants(10, seen);
    check("midrst_pending_dropped", seen, 0);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    wait_grant(1, 8, lat);
    check("midrst_new_latency", lat, 3);
    check("midrst_new_prio", grant_prio, 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
